clk_div_bank: RTL and testbench

Multi-channel, runtime-programmable clock divider for the lab board's 50 MHz domain. It generates `N_CH` independent divided clock enables/waveforms, each with a registered near-50% duty output and a one-cycle rising-edge tick. Each channel's divisor can be changed at runtime without glitches, and a global `sync` input phase-aligns all channels. Display-scan, debounce and 1 Hz timebase logic consume its outputs.

---
 rtl/clk_div_bank.sv | 163 ++++++++++++++++
 tb/tb_clk_div_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel runtime-programmable clock divider with registered near-50% waveforms and edge ticks.
// Optional macro CLK_DIV_SHADOW_EN: divisor writes wait in a shadow register until the next wrap.
module clk_div_bank #(
    parameter int          N_CH    = 4,
    parameter int          CW      = 32,
    parameter int unsigned DEF_DIV = 50000000,
    parameter int          SW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_50mhz,
    input  logic            rst_n,
    input  logic [N_CH-1:0] en,
    input  logic            sync,
    input  logic            wr,
    input  logic [SW-1:0]   wr_ch,
    input  logic [CW-1:0]   wr_div,
    output logic [N_CH-1:0] div_out,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] pend,
    output logic            wr_err
);

    localparam logic [CW-1:0] DEF_DIV_C = CW'(DEF_DIV);

    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [CW-1:0]   div_q [N_CH];
    logic [CW-1:0]   div_d [N_CH];
`ifdef CLK_DIV_SHADOW_EN
    logic [CW-1:0]   shadow_q [N_CH];
    logic [CW-1:0]   shadow_d [N_CH];
`endif
    logic [N_CH-1:0] out_q, out_d;
    logic [N_CH-1:0] tick_q, tick_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic            wr_err_q, wr_err_d;
    logic            wr_ok_s;

    // Write qualification: divisor must be at least 2 and the channel must exist.
    always_comb begin
        wr_ok_s  = wr && (wr_div >= CW'(2)) && (32'(wr_ch) < 32'(N_CH));
        wr_err_d = wr && !wr_ok_s;
    end

    // Per-channel next-state: sync beats disable, which beats normal counting.
    always_comb begin
        logic          hit_v;
        logic          wrap_v;
        logic [CW-1:0] hi_m1_v;
        for (int i = 0; i < N_CH; i++) begin
            hit_v   = wr_ok_s && (32'(wr_ch) == 32'(i));
            wrap_v  = (cnt_q[i] == div_q[i] - CW'(1));
            hi_m1_v = CW'(({1'b0, div_q[i]} + (CW+1)'(1)) >> 1) - CW'(1);
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            out_d[i]  = out_q[i];
            tick_d[i] = 1'b0;
            pend_d[i] = pend_q[i];
`ifdef CLK_DIV_SHADOW_EN
            shadow_d[i] = shadow_q[i];
`endif
            if (sync) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                if (hit_v) begin
                    div_d[i]  = wr_div;
                    pend_d[i] = 1'b0;
                end else begin
                    div_d[i] = div_q[i];
                end
            end else if (!en[i]) begin
                if (hit_v) begin
                    div_d[i]  = wr_div;
                    cnt_d[i]  = '0;
                    out_d[i]  = 1'b0;
                    pend_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
`ifdef CLK_DIV_SHADOW_EN
            end else if (wrap_v) begin
                cnt_d[i]  = '0;
                out_d[i]  = 1'b1;
                tick_d[i] = 1'b1;
                pend_d[i] = 1'b0;
                // A write landing on the wrap itself takes priority over an older shadow value.
                if (hit_v) begin
                    div_d[i] = wr_div;
                end else if (pend_q[i]) begin
                    div_d[i] = shadow_q[i];
                end else begin
                    div_d[i] = div_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
                if (cnt_q[i] == hi_m1_v) begin
                    out_d[i] = 1'b0;
                end else begin
                    out_d[i] = out_q[i];
                end
                if (hit_v) begin
                    shadow_d[i] = wr_div;
                    pend_d[i]   = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i];
                end
            end
`else
            end else if (hit_v) begin
                div_d[i] = wr_div;
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (wrap_v) begin
                cnt_d[i]  = '0;
                out_d[i]  = 1'b1;
                tick_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
                if (cnt_q[i] == hi_m1_v) begin
                    out_d[i] = 1'b0;
                end else begin
                    out_d[i] = out_q[i];
                end
            end
            pend_d[i] = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV_C;
`ifdef CLK_DIV_SHADOW_EN
                shadow_q[i] <= DEF_DIV_C;
`endif
            end
            out_q    <= '0;
            tick_q   <= '0;
            pend_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
`ifdef CLK_DIV_SHADOW_EN
                shadow_q[i] <= shadow_d[i];
`endif
            end
            out_q    <= out_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign div_out = out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: N_CH=2, DEF_DIV=4, hand-computed per-cycle expectations.
module tb_clk_div_bank;

    logic       clk_50mhz = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic       sync;
    logic       wr;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [1:0] div_out;
    logic [1:0] tick;
    logic [1:0] pend;
    logic       wr_err;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  o;
        logic [1:0]  t;
        logic [1:0]  p;
        logic        e;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    clk_div_bank #(.N_CH(2), .CW(8), .DEF_DIV(4), .SW(2)) dut (
        .clk_50mhz(clk_50mhz),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .wr       (wr),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .div_out  (div_out),
        .tick     (tick),
        .pend     (pend),
        .wr_err   (wr_err)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    // Monitor: counts edges and checks every expectation targeted at this edge.
    always @(posedge clk_50mhz) begin
        exp_t x;
        cyc = cyc + 1;
        #2;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            x = sb_q.pop_front();
            n_tests++;
            if (x.cyc != cyc || div_out !== x.o || tick !== x.t || pend !== x.p || wr_err !== x.e) begin
                n_fail++;
                $display("FAIL outputs@edge%0d: got div_out=%b tick=%b pend=%b wr_err=%b, want div_out=%b tick=%b pend=%b wr_err=%b (target edge %0d)",
                         cyc, div_out, tick, pend, wr_err, x.o, x.t, x.p, x.e, x.cyc);
            end
        end
    end

    task automatic step(input logic [1:0] e, input logic s, input logic w, input logic [1:0] ch,
                        input logic [7:0] dv, input logic [1:0] xo, input logic [1:0] xt,
                        input logic [1:0] xp, input logic xe);
        exp_t x;
        @(negedge clk_50mhz);
        en     = e;
        sync   = s;
        wr     = w;
        wr_ch  = ch;
        wr_div = dv;
        x.cyc  = cyc + 1;
        x.o    = xo;
        x.t    = xt;
        x.p    = xp;
        x.e    = xe;
        sb_q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 2'b00; sync = 1'b0; wr = 1'b0; wr_ch = 2'd0; wr_div = 8'd0;
        // Reset state.
        step(2'b00, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b00, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        // Reset release, D=4 on both channels: rises on edges 4, 8, 12.
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0); // 1
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 4
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 8
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 12
        // Rejected writes: divisor 1, then channel 3.
        step(2'b11, 1'b0, 1'b1, 2'd0, 8'd1, 2'b11, 2'b00, 2'b00, 1'b1); // 13
        step(2'b11, 1'b0, 1'b1, 2'd3, 8'd6, 2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 16
        // Channel 0 disabled for 7 edges while high.
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0); // 17
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10, 2'b00, 1'b0); // 20
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0); // 23
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b01, 2'b00, 1'b0); // 27
        // Sync with a coincident write of 8 to channel 1 (applies immediately).
        step(2'b11, 1'b1, 1'b1, 2'd1, 8'd8, 2'b00, 2'b00, 2'b00, 1'b0); // 28
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b01, 2'b00, 1'b0); // 32
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 36
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b01, 2'b00, 1'b0); // 40
`ifdef CLK_DIV_SHADOW_EN
        // Shadowed write of 5 to ch1 mid-period, then a wrap-coincident write of 2 to ch0.
        step(2'b11, 1'b0, 1'b1, 2'd1, 8'd5, 2'b01, 2'b00, 2'b10, 1'b0); // 41
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 44
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b1, 2'd0, 8'd2, 2'b01, 2'b01, 2'b00, 1'b0); // 48
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b10, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b01, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b01, 2'b00, 1'b0); // 52
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 54
`else
        // Immediate write of 6 to ch0 mid-period, later an immediate write of 5 to ch1.
        step(2'b11, 1'b0, 1'b1, 2'd0, 8'd6, 2'b00, 2'b00, 2'b00, 1'b0); // 41
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b10, 2'b00, 1'b0); // 44
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b01, 2'b00, 1'b0); // 47
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b1, 2'd1, 8'd5, 2'b01, 2'b00, 2'b00, 1'b0); // 49
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b01, 2'b00, 1'b0); // 53
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b10, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 2'b11, 2'b11, 2'b00, 1'b0); // 59
`endif
        @(negedge clk_50mhz);
        wr = 1'b0;
        for (int k = 0; k < 8 && sb_q.size() > 0; k++) begin
            @(negedge clk_50mhz);
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        // Asynchronous reset mid-period, both outputs currently high.
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (div_out !== 2'b00 || tick !== 2'b00 || pend !== 2'b00 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got div_out=%b tick=%b pend=%b wr_err=%b, want all 0",
                     div_out, tick, pend, wr_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
